// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the receive and transmit paths.
// Frame format is 8N1.
package uart_pkg;

    localparam int unsigned OSR_DEFAULT        = 16;
    localparam int unsigned SAMPLE_MID_DEFAULT = OSR_DEFAULT / 2;
    localparam int unsigned START_BITS         = 1;
    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned STOP_BITS          = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line plus a 1->0 edge detector.
// An edge only counts once the line has actually been observed high after reset.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic uart_clk,
    input  logic sys_rst_n,
    input  logic rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic       rxd_meta_q, rxd_meta_d;
    logic       rxd_s_q,    rxd_s_d;
    logic       rxd_prev_q, rxd_prev_d;
    logic [1:0] vld_q,      vld_d;

    // The reset value of the synchronizer is not a real observation of the line,
    // so the previous-value flop is only armed once vld_q[1] says rxd_s_q is real.
    always_comb begin
        rxd_meta_d = rxd;
        rxd_s_d    = rxd_meta_q;
        vld_d      = {vld_q[0], 1'b1};
        rxd_prev_d = vld_q[1] & rxd_s_q;
    end

    always_ff @(posedge uart_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_s_q    <= rxd_s_d;
            rxd_prev_q <= rxd_prev_d;
            vld_q      <= vld_d;
        end
    end

    assign rxd_s    = rxd_s_q;
    assign rxd_fall = rxd_prev_q & ~rxd_s_q;

endmodule

// File: rtl/uart_rx_v1.sv
// 8N1 UART receiver with oversampled 2-of-3 majority bit decisions and a
// FIFO write interface; returns to IDLE at the stop-bit decision.
module uart_rx_v1
    import uart_pkg::*;
#(
    parameter int unsigned OSR        = OSR_DEFAULT,
    parameter int unsigned SAMPLE_MID = OSR / 2
) (
    input  logic       uart_clk,
    input  logic       sys_rst_n,
    input  logic       rxd,
    input  logic       wr_full,
    output logic       wr_req,
    output logic [7:0] wr_data,
    output logic       recv_data_flag,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int unsigned CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(SAMPLE_MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(SAMPLE_MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(SAMPLE_MID + 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic rxd_s, rxd_fall;

    uart_rx_sync u_sync (
        .uart_clk  (uart_clk),
        .sys_rst_n (sys_rst_n),
        .rxd       (rxd),
        .rxd_s     (rxd_s),
        .rxd_fall  (rxd_fall)
    );

    rx_state_e     state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [1:0]    smp_q,     smp_d;
    logic          wr_req_q,  wr_req_d;
    logic          flag_q,    flag_d;
    logic          ferr_q,    ferr_d;
    logic          oerr_q,    oerr_d;
    logic          wrap, decide, bit_val;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        wr_data_d = wr_data_q;
        smp_d     = smp_q;
        wr_req_d  = 1'b0;
        flag_d    = 1'b0;
        ferr_d    = 1'b0;
        oerr_d    = 1'b0;

        wrap    = (cnt_q == CNT_LAST);
        decide  = (cnt_q == CNT_DEC);
        bit_val = maj3(smp_q[0], smp_q[1], rxd_s);

        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_S0) smp_d[0] = rxd_s;
            if (cnt_q == CNT_S1) smp_d[1] = rxd_s;
        end

        case (state_q)
            IDLE: begin
                if (rxd_fall) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (decide && bit_val) state_d = IDLE;
                else if (wrap)         state_d = DATA;
            end
            DATA: begin
                if (decide) shift_d = {bit_val, shift_q[7:1]};
                if (wrap) begin
                    if (bit_idx_q == BIT_LAST) state_d = STOP;
                    else                       bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving at the decision, not the wrap, lets the next start edge
                // land anywhere in the second half of this stop bit.
                if (decide) begin
                    state_d = IDLE;
                    if (!bit_val) begin
                        ferr_d = 1'b1;
                    end else if (wr_full) begin
                        oerr_d = 1'b1;
                    end else begin
                        wr_req_d  = 1'b1;
                        flag_d    = 1'b1;
                        wr_data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wr_data_q <= '0;
            smp_q     <= '0;
            wr_req_q  <= 1'b0;
            flag_q    <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_data_q <= wr_data_d;
            smp_q     <= smp_d;
            wr_req_q  <= wr_req_d;
            flag_q    <= flag_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
        end
    end

    assign wr_req         = wr_req_q;
    assign wr_data        = wr_data_q;
    assign recv_data_flag = flag_q;
    assign frame_err      = ferr_q;
    assign overrun_err    = oerr_q;

endmodule

// File: tb/tb_uart_rx_v1.sv
// Directed bench for uart_rx_v1: frames driven at the pin with hand-computed
// expected bytes, pulse counts and write latency.
module tb_uart_rx_v1;
    import uart_pkg::*;

    logic       uart_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       wr_full = 1'b0;
    logic       wr_req, recv_data_flag, frame_err, overrun_err;
    logic [7:0] wr_data;

    uart_rx_v1 #(.OSR(16), .SAMPLE_MID(8)) dut (
        .uart_clk       (uart_clk),
        .sys_rst_n      (sys_rst_n),
        .rxd            (rxd),
        .wr_full        (wr_full),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .recv_data_flag (recv_data_flag),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err)
    );

    always #5 uart_clk = ~uart_clk;

    int unsigned cyc = 0;
    always @(posedge uart_clk) cyc++;

    int unsigned n_wr = 0, n_flag = 0, n_ferr = 0, n_oerr = 0, n_coinc_bad = 0;
    int unsigned last_wr_cyc = 0;
    logic [7:0]  wr_log [$];

    always @(negedge uart_clk) begin
        if (wr_req) begin
            n_wr++;
            last_wr_cyc = cyc;
            wr_log.push_back(wr_data);
        end
        if (recv_data_flag) n_flag++;
        if (frame_err)      n_ferr++;
        if (overrun_err)    n_oerr++;
        if (wr_req != recv_data_flag) n_coinc_bad++;
    end

    int unsigned n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        else             n_pass++;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge uart_clk);
    endtask

    // Called at a negedge; rst_bit >= 0 pulses reset mid-way through that data bit.
    task automatic send_frame(input logic [7:0] data, input int bl, input logic stop_val,
                              input int rst_bit);
        rxd = 1'b0;
        idle_cycles(bl);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            if (i == rst_bit) begin
                idle_cycles(bl / 2);
                sys_rst_n = 1'b0;
                idle_cycles(1);
                chk("rst_wr_req",  32'(wr_req), 32'd0);
                chk("rst_wr_data", 32'(wr_data), 32'h00);
                chk("rst_flag",    32'(recv_data_flag), 32'd0);
                chk("rst_ferr",    32'(frame_err), 32'd0);
                chk("rst_oerr",    32'(overrun_err), 32'd0);
                chk("rst_state",   32'(dut.state_q), 32'(IDLE));
                idle_cycles(2);
                sys_rst_n = 1'b1;
                idle_cycles(bl - bl / 2 - 3);
            end else begin
                idle_cycles(bl);
            end
        end
        rxd = stop_val;
        idle_cycles(bl);
    endtask

    int unsigned t0, w0, f0, o0;

    initial begin
        idle_cycles(3);
        chk("reset_wr_req",  32'(wr_req), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'h00);
        chk("reset_flag",    32'(recv_data_flag), 32'd0);
        chk("reset_ferr",    32'(frame_err), 32'd0);
        chk("reset_oerr",    32'(overrun_err), 32'd0);
        sys_rst_n = 1'b1;
        idle_cycles(10);

        // 0x55 and its latency: rxd low after edge t0 -> rxd_s low at t0+2,
        // START at t0+3, wr_req registered 9*16+8+2 = 154 edges later.
        t0 = cyc; w0 = n_wr;
        send_frame(8'h55, 16, 1'b1, -1);
        idle_cycles(20);
        chk("x55_writes",  n_wr - w0, 32'd1);
        chk("x55_data",    32'(wr_log[$]), 32'h55);
        chk("x55_latency", last_wr_cyc - t0, 32'd157);
        chk("x55_flag",    n_flag, 32'd1);

        // Short low glitch is a false start.
        w0 = n_wr; f0 = n_ferr; o0 = n_oerr;
        rxd = 1'b0; idle_cycles(4); rxd = 1'b1; idle_cycles(40);
        chk("glitch_writes", n_wr - w0, 32'd0);
        chk("glitch_errs",   (n_ferr - f0) + (n_oerr - o0), 32'd0);
        chk("glitch_state",  32'(dut.state_q), 32'(IDLE));
        send_frame(8'hA3, 16, 1'b1, -1);
        idle_cycles(20);
        chk("a3_writes", n_wr - w0, 32'd1);
        chk("a3_data",   32'(wr_log[$]), 32'hA3);

        // Framing error followed by a 30-bit break.
        w0 = n_wr; f0 = n_ferr;
        send_frame(8'hA3, 16, 1'b0, -1);
        chk("ferr_pulse",  n_ferr - f0, 32'd1);
        rxd = 1'b0; idle_cycles(30 * 16);
        rxd = 1'b1; idle_cycles(40);
        chk("break_ferr",   n_ferr - f0, 32'd1);
        chk("ferr_writes",  n_wr - w0, 32'd0);

        // Overrun drops the byte; wr_data keeps the last written value.
        w0 = n_wr; o0 = n_oerr;
        wr_full = 1'b1;
        send_frame(8'h3C, 16, 1'b1, -1);
        idle_cycles(20);
        wr_full = 1'b0;
        chk("oerr_pulse",  n_oerr - o0, 32'd1);
        chk("oerr_writes", n_wr - w0, 32'd0);
        chk("oerr_hold",   32'(wr_data), 32'hA3);
        send_frame(8'h3C, 16, 1'b1, -1);
        idle_cycles(20);
        chk("x3c_writes", n_wr - w0, 32'd1);
        chk("x3c_data",   32'(wr_log[$]), 32'h3C);

        // Back-to-back frames with no idle gap, slow then fast bit periods.
        w0 = n_wr; f0 = n_ferr;
        send_frame(8'h00, 17, 1'b1, -1);
        send_frame(8'hFF, 15, 1'b1, -1);
        idle_cycles(30);
        chk("b2b_writes", n_wr - w0, 32'd2);
        chk("b2b_first",  32'(wr_log[$-1]), 32'h00);
        chk("b2b_second", 32'(wr_log[$]), 32'hFF);
        chk("b2b_ferr",   n_ferr - f0, 32'd0);

        // Reset during data bit 4 of 0x81 abandons the frame silently.
        w0 = n_wr; f0 = n_ferr; o0 = n_oerr;
        send_frame(8'h81, 16, 1'b1, 4);
        idle_cycles(30);
        chk("rstf_writes", n_wr - w0, 32'd0);
        chk("rstf_errs",   (n_ferr - f0) + (n_oerr - o0), 32'd0);
        send_frame(8'h81, 16, 1'b1, -1);
        idle_cycles(20);
        chk("x81_writes", n_wr - w0, 32'd1);
        chk("x81_data",   32'(wr_log[$]), 32'h81);

        chk("flag_coincident", n_coinc_bad, 32'd0);
        chk("flag_count",      n_flag, n_wr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
